// File: rtl/game_config.sv
// Shared game-wide configuration: raster geometry, colour width and default
// sprite colour, plus a small helper for sizing index fields.
package game_config;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int RGB_W         = 3;

  localparam logic [RGB_W-1:0] DEFAULT_SPRITE_RGB = 3'b111;

  // Width of a field able to index n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_sprite_rom.sv
// Combinational sprite mask lookup.
// Ports:
//   row    - sprite-relative row, 0 is the top row
//   col    - sprite-relative column, 0 is the leftmost column
//   opaque - mask bit at row*SPRITE_WIDTH + col
module game_sprite_rom
  import game_config::*;
#(
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter logic [SPRITE_WIDTH*SPRITE_HEIGHT-1:0] SPRITE_MASK = '1
) (
  input  logic [idx_w(SPRITE_HEIGHT)-1:0] row,
  input  logic [idx_w(SPRITE_WIDTH)-1:0]  col,
  output logic                            opaque
);

  localparam int NPIX = SPRITE_WIDTH * SPRITE_HEIGHT;
  localparam int IW   = idx_w(NPIX);

  logic [IW-1:0] idx;

  assign idx    = IW'(int'(row) * SPRITE_WIDTH + int'(col));
  assign opaque = SPRITE_MASK[idx];

endmodule

// File: rtl/game_sprite_display.sv
// Single-sprite overlay for a raster display.
// Sprite position is latched once per frame so moves never tear; the raster
// position is pushed through a free-running 2-stage pipeline that reports
// whether the pixel is an opaque sprite pixel and its colour.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   frame_start         - one-cycle pulse at the start of each frame
//   display_on, x, y    - raster pixel valid and position
//   sprite_x, sprite_y  - sprite top-left from the sprite controller
//   sprite_within       - opaque sprite pixel, 2 cycles after x/y
//   sprite_rgb          - sprite colour when sprite_within, else 0
//   sprite_visible      - previous frame drew at least one sprite pixel
module game_sprite_display
  import game_config::*;
#(
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int screen_width  = SCREEN_WIDTH,
  parameter int screen_height = SCREEN_HEIGHT,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter logic [SPRITE_WIDTH*SPRITE_HEIGHT-1:0] SPRITE_MASK = '1,
  parameter logic [RGB_W-1:0] SPRITE_RGB = DEFAULT_SPRITE_RGB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             display_on,
  input  logic [w_x-1:0]   x,
  input  logic [w_y-1:0]   y,
  input  logic [w_x-1:0]   sprite_x,
  input  logic [w_y-1:0]   sprite_y,
  output logic             sprite_within,
  output logic [RGB_W-1:0] sprite_rgb,
  output logic             sprite_visible
);

  localparam int CW = idx_w(SPRITE_WIDTH);
  localparam int RW = idx_w(SPRITE_HEIGHT);

  // Per-frame shadow of the sprite position.
  logic [w_x-1:0] lx;
  logic [w_y-1:0] ly;

  // Stage-1 combinational terms. The extra MSB is the borrow, so a raster
  // position left of / above the sprite never aliases into it and x never
  // wraps for sprites hanging off the right edge.
  logic [w_x:0] rx;
  logic [w_y:0] ry;
  logic         inside_d;

  assign rx = {1'b0, x} - {1'b0, lx};
  assign ry = {1'b0, y} - {1'b0, ly};

  assign inside_d = display_on && !rx[w_x] && !ry[w_y] &&
                    (rx < (w_x+1)'(SPRITE_WIDTH)) &&
                    (ry < (w_y+1)'(SPRITE_HEIGHT));

  // Stage-1 registers.
  logic          s1_inside;
  logic [CW-1:0] s1_col;
  logic [RW-1:0] s1_row;

  // Mask lookup; address forced to 0 unless the pixel is inside the sprite.
  logic [CW-1:0] rom_col;
  logic [RW-1:0] rom_row;
  logic          opaque;
  logic          hit;

  assign rom_col = s1_inside ? s1_col : '0;
  assign rom_row = s1_inside ? s1_row : '0;
  assign hit     = s1_inside && opaque;

  game_sprite_rom #(
    .SPRITE_WIDTH  (SPRITE_WIDTH),
    .SPRITE_HEIGHT (SPRITE_HEIGHT),
    .SPRITE_MASK   (SPRITE_MASK)
  ) u_rom (
    .row    (rom_row),
    .col    (rom_col),
    .opaque (opaque)
  );

  // Frame-boundary latch. A pixel entering stage 1 on the frame_start cycle
  // still sees the old lx/ly, since they change only at this edge.
  // NOTE: every register here is async-reset; there is no memory array, so
  // nothing is left uninitialised and no output can glitch high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lx <= '0;
      ly <= '0;
    end else if (frame_start) begin
      lx <= sprite_x;
      ly <= sprite_y;
    end
  end

  // NOTE: non-blocking assignments keep the two stages one cycle apart;
  // blocking ones would collapse the pipeline into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_inside     <= 1'b0;
      s1_col        <= '0;
      s1_row        <= '0;
      sprite_within <= 1'b0;
      sprite_rgb    <= '0;
    end else begin
      s1_inside     <= inside_d;
      s1_col        <= rx[CW-1:0];
      s1_row        <= ry[RW-1:0];
      sprite_within <= hit;
      sprite_rgb    <= hit ? SPRITE_RGB : '0;
    end
  end

  // Frame visibility. A pixel drawn on the frame_start cycle belongs to the
  // new frame, so set takes priority over clear.
  logic seen_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_acc       <= 1'b0;
      sprite_visible <= 1'b0;
    end else begin
      if (frame_start)
        sprite_visible <= seen_acc;
      if (sprite_within)
        seen_acc <= 1'b1;
      else if (frame_start)
        seen_acc <= 1'b0;
    end
  end

endmodule
